multicycle_ctrl: RTL and testbench

Multi-cycle sequencing controller for the RV32 integer core. It replaces single-cycle operation with a FETCH/DECODE/EXEC/WB state machine and handshakes with a variable-latency instruction memory. It drives the existing datapath control set (RegWrite, ALUSrc, ALUOp), plus PC and IR write enables. It sits between the instruction memory port and the register file/ALU, and supports R-type (0110011) and I-type ALU (0010011) opcodes.

---
 rtl/multicycle_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Multi-cycle sequencing controller for the RV32 integer core. It steps each
// instruction through FETCH -> DECODE -> EXEC -> WB. It handshakes with a
// variable-latency instruction memory. It drives the datapath control set
// (RegWrite, ALUSrc, ALUOp) and the PC/IR write enables.
// Supported opcodes: R-type (0110011) and I-type ALU (0010011).
//
// Parameters:
//   FETCH_TIMEOUT  maximum FETCH cycles without imem_ack_i before a fault
//                  (0 disables the timeout)
// Optional feature macro:
//   CTRL_INSTRET_EN  adds the instret_o retired-instruction counter
//
// Ports:
//   clk_i       clock, rising edge
//   rst_i       asynchronous active-high reset
//   start_i     run enable, level-sensitive; sampled in IDLE and WB only
//   imem_req_o  instruction fetch request (FETCH)
//   imem_ack_i  fetch data valid; IR captures it this cycle
//   opcode_i    IR[6:0]; sampled in DECODE only
//   ir_write_o  IR load enable (FETCH && imem_ack_i)
//   pc_write_o  PC <= PC+4 enable (WB)
//   RegWrite    register file write enable (WB of a legal instruction)
//   ALUSrc      0 = rs2, 1 = immediate (EXEC/WB)
//   ALUOp       2'b10 = R-type decode, 2'b00 = add/I-type (EXEC/WB)
//   illegal_o   one-cycle pulse in WB for an unsupported opcode
//   fault_o     sticky fetch-timeout flag
//   busy_o      high in every state except IDLE and HALT
//   instret_o   retired-instruction count (CTRL_INSTRET_EN only)
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int FETCH_TIMEOUT = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  output logic       imem_req_o,
  input  logic       imem_ack_i,
  input  logic [6:0] opcode_i,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic       RegWrite,
  output logic       ALUSrc,
  output logic [1:0] ALUOp,
  output logic       illegal_o,
  output logic       fault_o,
  output logic       busy_o
`ifdef CTRL_INSTRET_EN
  ,
  output logic [31:0] instret_o
`endif
);

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;

  // The wait counter only needs to reach FETCH_TIMEOUT-1: the cycle that
  // would bring it to FETCH_TIMEOUT is the one that trips the fault.
  localparam int CW = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, WB, HALT
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   wait_cnt_q;
  logic            fault_q;
  logic            legal_q, alusrc_q;
  logic [1:0]      aluop_q;
  logic            dec_legal, dec_alusrc;
  logic [1:0]      dec_aluop;
  logic            fetch_timeout;

  assign fetch_timeout = (FETCH_TIMEOUT != 0) &&
                         (wait_cnt_q == CW'(FETCH_TIMEOUT - 1));

  // Opcode decode; only registered while in DECODE.
  always_comb begin
    dec_legal  = 1'b0;
    dec_alusrc = 1'b0;
    dec_aluop  = 2'b00;
    case (opcode_i)
      OP_RTYPE: begin
        dec_legal = 1'b1;
        dec_aluop = 2'b10;
      end
      OP_ITYPE: begin
        dec_legal  = 1'b1;
        dec_alusrc = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      fault_q    <= 1'b0;
      legal_q    <= 1'b0;
      alusrc_q   <= 1'b0;
      aluop_q    <= 2'b00;
    end else begin
      state_q <= state_d;

      // Counter is held at zero outside FETCH, so it is clear on entry.
      if (state_q != FETCH)
        wait_cnt_q <= '0;
      else if (!imem_ack_i && FETCH_TIMEOUT != 0 && !fetch_timeout)
        wait_cnt_q <= wait_cnt_q + CW'(1);

      if (state_q == FETCH && !imem_ack_i && fetch_timeout)
        fault_q <= 1'b1;

      if (state_q == DECODE) begin
        legal_q  <= dec_legal;
        alusrc_q <= dec_alusrc;
        aluop_q  <= dec_aluop;
      end
    end
  end

  // NOTE: every output and next-state value gets a default before the case so
  // no path through the block can infer a latch.
  always_comb begin
    state_d    = state_q;
    imem_req_o = 1'b0;
    ir_write_o = 1'b0;
    pc_write_o = 1'b0;
    RegWrite   = 1'b0;
    ALUSrc     = 1'b0;
    ALUOp      = 2'b00;
    illegal_o  = 1'b0;
    busy_o     = 1'b1;
    case (state_q)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) state_d = FETCH;
      end
      FETCH: begin
        imem_req_o = 1'b1;
        // Ack wins over a timeout landing in the same cycle.
        if (imem_ack_i) begin
          ir_write_o = 1'b1;
          state_d    = DECODE;
        end else if (fetch_timeout) begin
          state_d = HALT;
        end
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        ALUSrc  = alusrc_q;
        ALUOp   = aluop_q;
        state_d = WB;
      end
      WB: begin
        ALUSrc     = alusrc_q;
        ALUOp      = aluop_q;
        RegWrite   = legal_q;
        pc_write_o = 1'b1;
        illegal_o  = !legal_q;
        state_d    = start_i ? FETCH : IDLE;
      end
      HALT: busy_o = 1'b0;
      default: begin
        busy_o  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign fault_o = fault_q;

`ifdef CTRL_INSTRET_EN
  logic [31:0] instret_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      instret_q <= '0;
    else if (state_q == WB && legal_q)
      instret_q <= instret_q + 32'd1;
  end

  assign instret_o = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
// Testbench for multicycle_ctrl. The stimulus thread issues instructions and
// pushes the expected writeback into a scoreboard queue. A separate monitor
// pops one entry and compares it each time the DUT presents a WB cycle
// (pc_write_o high).
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  localparam logic [6:0] OP_ADD  = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        imem_ack_i = 1'b0;
  logic [6:0]  opcode_i = 7'd0;
  logic        imem_req_o, ir_write_o, pc_write_o, RegWrite, ALUSrc;
  logic [1:0]  ALUOp;
  logic        illegal_o, fault_o, busy_o;
`ifdef CTRL_INSTRET_EN
  logic [31:0] instret_o;
`endif

  multicycle_ctrl #(.FETCH_TIMEOUT(16)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .imem_req_o (imem_req_o),
    .imem_ack_i (imem_ack_i),
    .opcode_i   (opcode_i),
    .ir_write_o (ir_write_o),
    .pc_write_o (pc_write_o),
    .RegWrite   (RegWrite),
    .ALUSrc     (ALUSrc),
    .ALUOp      (ALUOp),
    .illegal_o  (illegal_o),
    .fault_o    (fault_o),
    .busy_o     (busy_o)
`ifdef CTRL_INSTRET_EN
    ,
    .instret_o  (instret_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         wb_cyc;
    logic       rw;
    logic       src;
    logic [1:0] op;
    logic       ill;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every WB cycle must match the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (pc_write_o === 1'b1) begin
        check("wb_expected", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("wb_cycle",    cyc,       e.wb_cyc);
          check("wb_regwrite", RegWrite,  e.rw);
          check("wb_alusrc",   ALUSrc,    e.src);
          check("wb_aluop",    ALUOp,     e.op);
          check("wb_illegal",  illegal_o, e.ill);
        end
      end
    end
  end

  // Runs one instruction. Caller must be at a negedge with the FSM in IDLE
  // (start_i high) or in the first cycle of FETCH.
  task automatic do_instr(input logic [6:0] op, input int delay,
                          input logic legal, input logic src,
                          input logic [1:0] aop, input logic next_start,
                          input bit rst_exec);
    int n = 0;
    exp_t e;
    while (!imem_req_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    check("fetch_reached", imem_req_o, 1);
    check("fault_low", fault_o, 0);
    for (int i = 0; i < delay; i++) begin
      check("no_ir_write_wait", ir_write_o, 0);
      @(negedge clk_i);
      check("req_held", imem_req_o, 1);
    end
    imem_ack_i = 1'b1;
    opcode_i   = op;
    #1;
    check("ir_write", ir_write_o, 1);
    if (!rst_exec) begin
      e.wb_cyc = cyc + 3;
      e.rw     = legal;
      e.src    = src;
      e.op     = aop;
      e.ill    = !legal;
      sb.push_back(e);
    end
    @(negedge clk_i);                       // DECODE
    check("ack_ignored_decode", ir_write_o, 0);
    imem_ack_i = 1'b0;
    check("decode_req",    imem_req_o, 0);
    check("decode_busy",   busy_o, 1);
    check("decode_alusrc", ALUSrc, 0);
    check("decode_aluop",  ALUOp, 0);
    @(negedge clk_i);                       // EXEC
    opcode_i = 7'h7f;                       // must not affect the held set
    check("exec_alusrc",   ALUSrc, src);
    check("exec_aluop",    ALUOp, aop);
    check("exec_regwrite", RegWrite, 0);
    check("exec_pcwrite",  pc_write_o, 0);
    if (rst_exec) begin
      rst_i = 1'b1;
      #1;
      check("rst_exec_outputs",
            {imem_req_o, ir_write_o, pc_write_o, RegWrite, ALUSrc, ALUOp,
             illegal_o, fault_o, busy_o}, 0);
      @(negedge clk_i);
      check("rst_no_wb", pc_write_o, 0);
      rst_i = 1'b0;
      #1;
      check("rst_idle_busy", busy_o, 0);
      return;
    end
    start_i = next_start;
    @(negedge clk_i);                       // WB (monitor compares)
    @(negedge clk_i);
    check("post_wb_req",     imem_req_o, next_start);
    check("post_wb_busy",    busy_o, next_start);
    check("illegal_one_cyc", illegal_o, 0);
    check("post_wb_pcwrite", pc_write_o, 0);
  endtask

  initial begin
    int count;
    #1;
    check("reset_outputs",
          {imem_req_o, ir_write_o, pc_write_o, RegWrite, ALUSrc, ALUOp,
           illegal_o, fault_o, busy_o}, 0);
`ifdef CTRL_INSTRET_EN
    check("reset_instret", instret_o, 0);
`endif
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("idle_busy", busy_o, 0);
    check("idle_req",  imem_req_o, 0);

    start_i = 1'b1;
    do_instr(OP_ADD,   0, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0);
    do_instr(OP_ADDI,  3, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0);
    do_instr(OP_LOAD,  1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    // Ack on the 16th FETCH cycle: ack wins over the timeout.
    do_instr(OP_ADD,  15, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0);
    check("ack_wins_fault", fault_o, 0);
    // start_i dropped mid-instruction: finish, then return to IDLE.
    do_instr(OP_ADDI,  0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
    repeat (2) @(negedge clk_i);
    check("idle_after_stop", busy_o, 0);

`ifdef CTRL_INSTRET_EN
    force dut.instret_q = 32'hFFFF_FFFF;
    @(negedge clk_i);
    release dut.instret_q;
    start_i = 1'b1;
    do_instr(OP_ADD,  0, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0);
    check("instret_wrap", instret_o, 32'd0);
    do_instr(OP_LOAD, 0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    check("instret_illegal_hold", instret_o, 32'd0);
    do_instr(OP_ADDI, 2, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0);
    check("instret_incr", instret_o, 32'd1);
`else
    start_i = 1'b1;
`endif

    // Reset during EXEC, then restart from IDLE.
    do_instr(OP_ADD,  2, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1);
    do_instr(OP_ADDI, 0, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0);

    // Fetch timeout: ack never asserted.
    count = 0;
    while (imem_req_o && count < 40) begin
      check("timeout_no_fault_yet", fault_o, 0);
      count++;
      @(negedge clk_i);
    end
    check("timeout_cycles", count, 16);
    check("halt_fault", fault_o, 1);
    check("halt_busy",  busy_o, 0);
    check("halt_req",   imem_req_o, 0);
    repeat (5) @(negedge clk_i);
    imem_ack_i = 1'b1;
    #1;
    check("halt_ack_ignored", ir_write_o, 0);
    check("halt_sticky",      fault_o, 1);
    check("halt_stays",       busy_o, 0);
    imem_ack_i = 1'b0;
    rst_i = 1'b1;
    #1;
    check("rst_clears_fault", fault_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    check("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
